// File: rtl/ringosc_ctrl.sv
// ringosc_ctrl -- ring-oscillator frequency measurement controller.
//
// Enables an external ring oscillator, lets it settle for WARMUP clk cycles,
// then counts rising edges of its (synchronised) output over a window of
// gate_len clk cycles. The result is held on count/overflow until the next
// accepted start.
//
// Parameters:
//   CNT_W    width of the edge counter / count result
//   WARMUP   clk cycles the oscillator runs before counting (>= 1)
//
// Ports:
//   clk       system clock, all state on its rising edge
//   rst_n     asynchronous active-low reset
//   start     measurement request, sampled only while idle
//   abort     cancel a measurement in warm-up or measure
//   gate_len  window length in clk cycles, latched on an accepted start
//   osc_in    ring oscillator output, asynchronous to clk
//   osc_en    ring oscillator enable (registered)
//   busy      high whenever a measurement is in progress or completing
//   done      one-cycle pulse when count/overflow are final
//   count     rising edges seen in the last window (saturating)
//   overflow  counter saturated during the last window
//
// Accuracy needs an osc_in period of at least 4 clk cycles; faster inputs
// alias through the synchroniser and edge detector.
module ringosc_ctrl #(
  parameter int CNT_W  = 16,
  parameter int WARMUP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      gate_len,
  input  logic             osc_in,
  output logic             osc_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  // One timer serves both the warm-up and the gate window, so it must be
  // wide enough for whichever of the two is longer.
  localparam int WU_W  = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int TMR_W = (WU_W > 16) ? WU_W : 16;
  localparam logic [TMR_W-1:0] WU_LAST  = TMR_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_MEASURE,
    ST_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [TMR_W-1:0]   timer_reg;
  logic [15:0]        gate_len_reg;
  logic               sync1_reg, sync_reg, prev_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               ovf_reg;
  logic               osc_en_reg;

  logic               start_ok;
  logic               abort_ok;
  logic               rise;
  logic [TMR_W-1:0]   gate_last;

  assign start_ok  = (state_reg == ST_IDLE) && start && !abort;
  assign abort_ok  = abort && ((state_reg == ST_WARMUP) || (state_reg == ST_MEASURE));
  assign rise      = sync_reg & ~prev_reg;
  // Only consulted when gate_len_reg is non-zero, so no wrap concern.
  assign gate_last = TMR_W'(gate_len_reg) - TMR_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_ok) state_next = ST_WARMUP;
      end
      ST_WARMUP: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (timer_reg == WU_LAST) begin
          // A zero-length window skips MEASURE entirely so the oscillator
          // runs for exactly the warm-up period.
          state_next = (gate_len_reg == 16'd0) ? ST_DONE : ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (timer_reg == gate_last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Phase timer restarts from 0 on every state change, so it always holds
  // the number of cycles already spent in the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reg <= '0;
    end else if ((state_next != state_reg) || (state_reg == ST_IDLE)) begin
      timer_reg <= '0;
    end else begin
      timer_reg <= timer_reg + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_len_reg <= '0;
    end else if (start_ok) begin
      gate_len_reg <= gate_len;
    end
  end

  // Two-flop synchroniser followed by a rising-edge detector. prev_reg
  // tracks sync_reg every cycle so no stale edge is seen on entering MEASURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync_reg  <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= osc_in;
      sync_reg  <= sync1_reg;
      prev_reg  <= sync_reg;
    end
  end

  // Saturating edge counter; result stays put through DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (start_ok || abort_ok) begin
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
    end else if ((state_reg == ST_MEASURE) && rise) begin
      if (cnt_reg == CNT_MAX) begin
        ovf_reg <= 1'b1;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      osc_en_reg <= 1'b0;
    end else begin
      osc_en_reg <= (state_next == ST_WARMUP) || (state_next == ST_MEASURE);
    end
  end

  assign osc_en   = osc_en_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign done     = (state_reg == ST_DONE);
  assign count    = cnt_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_ringosc_ctrl.sv
// Testbench for ringosc_ctrl. Two instances share all inputs: one with the
// default 16-bit counter and one with a 4-bit counter to reach saturation.
// Expected edge counts come from the recorded osc_in waveform: an edge is
// credited to a window cycle when the input level two cycles earlier is high
// and three cycles earlier is low (2-flop synchroniser plus edge detector).
module tb_ringosc_ctrl;
  localparam int WU = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        osc_in = 1'b0;
  logic [15:0] gate_len = 16'd0;

  logic        osc_en, busy, done, overflow;
  logic [15:0] count;
  logic        osc_en4, busy4, done4, overflow4;
  logic [3:0]  count4;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  bit hist [0:32767];
  int osc_half = 0;
  bit osc_rand = 1'b0;

  ringosc_ctrl #(.CNT_W(16), .WARMUP(WU)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .gate_len(gate_len), .osc_in(osc_in), .osc_en(osc_en), .busy(busy),
    .done(done), .count(count), .overflow(overflow)
  );

  ringosc_ctrl #(.CNT_W(4), .WARMUP(WU)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .gate_len(gate_len), .osc_in(osc_in), .osc_en(osc_en4), .busy(busy4),
    .done(done4), .count(count4), .overflow(overflow4)
  );

  always #5 clk = ~clk;

  // Oscillator stimulus: fixed half-period, or random levels held 2..5 cycles
  // (period never below 4 clk cycles). hist[k] is the level driven after
  // posedge k.
  initial begin
    int ph;
    int hold;
    ph = 0;
    hold = 2;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (osc_rand) begin
        ph++;
        if (ph >= hold) begin
          ph = 0;
          hold = $urandom_range(2, 5);
          osc_in = ~osc_in;
        end
      end else if (osc_half == 0) begin
        ph = 0;
        osc_in = 1'b0;
      end else begin
        ph++;
        if (ph >= osc_half) begin
          ph = 0;
          osc_in = ~osc_in;
        end
      end
      hist[cyc & 32767] = osc_in;
    end
  end

  // Edges credited to a window whose start was driven after posedge c.
  function automatic int model_edges(input int c, input int g);
    int e;
    e = 0;
    for (int p = c + WU + 1; p <= c + WU + g; p++) begin
      if (hist[(p - 2) & 32767] && !hist[(p - 3) & 32767]) e++;
    end
    return e;
  endfunction

  // One complete measurement. poke re-asserts start with a new gate_len
  // mid-window; abort_done raises abort during the DONE cycle.
  task automatic do_run(input int g, input bit poke, input bit abort_done, input string name);
    int c, e, en_cnt;
    bit seen;
    logic [15:0] e16;
    logic [3:0]  e4;
    logic        o16, o4;
    @(posedge clk); #1;
    gate_len = 16'(g);
    start = 1'b1;
    c = cyc;
    en_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < WU + g + 20 && !seen; i++) begin
      @(posedge clk); #1;
      start = (poke && g > 12 && cyc == c + WU + 10);
      gate_len = 16'($urandom());
      abort = (abort_done && cyc == c + WU + g + 1);
      @(negedge clk);
      if (osc_en) en_cnt++;
      if (done) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b1) $display("FAIL %s timeout: done=%b required=1 within %0d cycles", name, done, WU + g + 20);
    else n_pass++;
    if (seen) begin
      e   = model_edges(c, g);
      e16 = (e > 65535) ? 16'hFFFF : 16'(e);
      o16 = (e > 65535);
      e4  = (e > 15) ? 4'hF : 4'(e);
      o4  = (e > 15);
      n_checks++;
      if (cyc !== c + WU + g + 1) $display("FAIL %s done_latency: cycle=%0d required=%0d", name, cyc - c, WU + g + 1);
      else n_pass++;
      n_checks++;
      if (en_cnt !== WU + g) $display("FAIL %s osc_en_cycles: got=%0d required=%0d", name, en_cnt, WU + g);
      else n_pass++;
      n_checks++;
      if ({count, overflow} !== {e16, o16}) $display("FAIL %s count16: got=%0d/%b required=%0d/%b", name, count, overflow, e16, o16);
      else n_pass++;
      n_checks++;
      if ({count4, overflow4, done4} !== {e4, o4, 1'b1}) $display("FAIL %s count4: got=%0d/%b done=%b required=%0d/%b", name, count4, overflow4, done4, e4, o4);
      else n_pass++;
      $display("run %s gate=%0d edges=%0d count=%0d ovf=%b count4=%0d ovf4=%b", name, g, e, count, overflow, count4, overflow4);
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({done, busy, osc_en, count, overflow} !== {3'b000, e16, o16})
        $display("FAIL %s after_done: done=%b busy=%b osc_en=%b count=%0d required 0/0/0 count=%0d", name, done, busy, osc_en, count, e16);
      else n_pass++;
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b1;
    gate_len = 16'd10;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({osc_en, busy, done, count, overflow, osc_en4, busy4, done4, count4, overflow4} !== '0)
      $display("FAIL reset_state: osc_en=%b busy=%b done=%b count=%0d ovf=%b required all 0", osc_en, busy, done, count, overflow);
    else n_pass++;
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, osc_en} !== 2'b00) $display("FAIL reset_release: busy=%b osc_en=%b required 0/0", busy, osc_en);
    else n_pass++;
    $display("reset done");
  endtask

  task automatic test_basic();
    osc_rand = 1'b0;
    osc_half = 4;
    do_run(80, 1'b0, 1'b0, "basic");
    n_checks++;
    if ({count, overflow} !== {16'd10, 1'b0}) $display("FAIL basic_const: count=%0d ovf=%b required 10/0", count, overflow);
    else n_pass++;
  endtask

  task automatic test_saturate();
    osc_half = 2;
    do_run(100, 1'b0, 1'b0, "saturate");
    n_checks++;
    if ({count4, overflow4, count} !== {4'd15, 1'b1, 16'd25}) $display("FAIL sat_const: count4=%0d ovf4=%b count=%0d required 15/1/25", count4, overflow4, count);
    else n_pass++;
    do_run(8, 1'b0, 1'b0, "after_sat");
    n_checks++;
    if ({count4, overflow4} !== {4'd2, 1'b0}) $display("FAIL after_sat_const: count4=%0d ovf4=%b required 2/0", count4, overflow4);
    else n_pass++;
  endtask

  task automatic test_zero_gate();
    do_run(0, 1'b0, 1'b0, "zero_gate");
    n_checks++;
    if ({count, overflow} !== 17'd0) $display("FAIL zero_gate_const: count=%0d ovf=%b required 0/0", count, overflow);
    else n_pass++;
  endtask

  task automatic test_abort(input int when, input string name);
    int c, dones;
    osc_half = 2;
    @(posedge clk); #1;
    gate_len = 16'd60;
    start = 1'b1;
    c = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < c + when) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, osc_en, done, count, overflow, count4, overflow4} !== '0)
      $display("FAIL %s state: busy=%b osc_en=%b done=%b count=%0d ovf=%b required all 0", name, busy, osc_en, done, count, overflow);
    else n_pass++;
    dones = 0;
    repeat (80) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    n_checks++;
    if (dones !== 0) $display("FAIL %s no_done: busy_or_done_cycles=%0d required 0", name, dones);
    else n_pass++;
    $display("abort %s at cycle offset %0d", name, when);
  endtask

  task automatic test_back_to_back();
    osc_rand = 1'b1;
    do_run(40, 1'b1, 1'b0, "ignored_start");
    do_run(30, 1'b0, 1'b1, "abort_in_done");
  endtask

  task automatic test_start_abort_idle();
    logic [15:0] held;
    @(posedge clk); #1;
    held = count;
    start = 1'b1;
    abort = 1'b1;
    gate_len = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, osc_en, done, count} !== {3'b000, held})
      $display("FAIL start_abort_idle: busy=%b osc_en=%b count=%0d required 0/0 count=%0d", busy, osc_en, count, held);
    else n_pass++;
    $display("start+abort in idle, count held at %0d", held);
  endtask

  task automatic test_reset_warmup();
    osc_half = 3;
    osc_rand = 1'b0;
    @(posedge clk); #1;
    gate_len = 16'd30;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, osc_en} !== 2'b11) $display("FAIL rst_pre: busy=%b osc_en=%b required 1/1", busy, osc_en);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({osc_en, busy, done, count, overflow, osc_en4, busy4, count4} !== '0)
      $display("FAIL rst_warmup: osc_en=%b busy=%b done=%b count=%0d required all 0", osc_en, busy, done, count);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("reset during warm-up");
    do_run(24, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      osc_rand = ($urandom_range(0, 1) == 1);
      osc_half = $urandom_range(2, 6);
      do_run($urandom_range(0, 120), ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_zero_gate();
    test_abort(WU + 20, "measure");
    test_abort(3, "warmup");
    test_back_to_back();
    test_start_abort_idle();
    test_reset_warmup();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: time=%0t required finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
